// File: rtl/pipe_control_unit.sv
// Control unit for the five-stage MIPS pipeline: decode, control-bundle pipeline,
// load-use and multiply interlocks, branch/jump flushing and MULTU sequencing.
module pipe_control_unit #(
    parameter int MUL_LATENCY = 32,
    parameter int CNT_W       = 8,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    output logic [3:0]       EX,
    output logic [2:0]       MEM,
    output logic [1:0]       WB,
    output logic             Jump,
    output logic             JumpReg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_ifid,
    output logic             mul_start,
    output logic             mul_busy,
    output logic             hilo_write,
    output logic             illegal_op
);

    // state | meaning
    // IDLE  | multiplier free, HI/LO valid
    // BUSY  | MULTU in flight, cnt counts down to 1
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;

    logic [3:0]       dec_ex;
    logic [2:0]       dec_mem;
    logic [1:0]       dec_wb;
    logic             op_rtype;
    logic             op_beq;
    logic             op_sw;
    logic             op_multu;
    logic             op_mfhilo;
    logic             stall_lu;
    logic             stall_mul;
    logic             stall;
    logic             mul_go;
    logic [2:0]       idex_mem;
    logic [1:0]       idex_wb;
    logic [1:0]       exmem_wb;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        dec_ex     = 4'b0000;
        dec_mem    = 3'b000;
        dec_wb     = 2'b00;
        Jump       = 1'b0;
        JumpReg    = 1'b0;
        illegal_op = 1'b0;
        op_rtype   = 1'b0;
        op_beq     = 1'b0;
        op_sw      = 1'b0;
        op_multu   = 1'b0;
        op_mfhilo  = 1'b0;
        case (OpCode)
            OP_LW: begin
                dec_ex  = 4'b0001;
                dec_mem = 3'b100;
                dec_wb  = 2'b11;
            end
            OP_SW: begin
                op_sw   = 1'b1;
                dec_ex  = 4'b0001;
                dec_mem = 3'b010;
            end
            OP_BEQ: begin
                op_beq  = 1'b1;
                dec_ex  = 4'b0010;
                dec_mem = 3'b001;
            end
            OP_ANDI: begin
                dec_ex = 4'b0111;
                dec_wb = 2'b10;
            end
            OP_J: begin
                Jump = 1'b1;
            end
            OP_RTYPE: begin
                op_rtype = 1'b1;
                case (Funct)
                    FN_JR: begin
                        Jump    = 1'b1;
                        JumpReg = 1'b1;
                    end
                    FN_MULTU: begin
                        op_multu = 1'b1;
                        dec_ex   = 4'b1100;
                    end
                    FN_MFHI, FN_MFLO: begin
                        op_mfhilo = 1'b1;
                        dec_ex    = 4'b1100;
                        dec_wb    = 2'b10;
                    end
                    default: begin
                        dec_ex = 4'b1100;
                        dec_wb = 2'b10;
                    end
                endcase
            end
            default: illegal_op = 1'b1;
        endcase
    end

    // rt is a source only for R-type, BEQ and SW; for the rest it is the destination
    assign stall_lu  = idex_mem[2] && (ex_rt != '0) &&
                       ((ex_rt == id_rs) || ((ex_rt == id_rt) && (op_rtype || op_beq || op_sw)));
    assign stall_mul = mul_busy && (op_mfhilo || op_multu);
    assign stall     = stall_lu || stall_mul;

    // a taken branch discards everything younger, so any stall is moot
    assign pc_write   = branch_taken || !stall;
    assign ifid_write = branch_taken || !stall;
    assign flush_ifid = branch_taken || (Jump && !stall);
    assign mul_go     = op_multu && !stall && !branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            EX       <= '0;
            idex_mem <= '0;
            idex_wb  <= '0;
            MEM      <= '0;
            exmem_wb <= '0;
            WB       <= '0;
        end else begin
            WB <= exmem_wb;
            if (branch_taken) begin
                EX       <= '0;
                idex_mem <= '0;
                idex_wb  <= '0;
                MEM      <= '0;
                exmem_wb <= '0;
            end else begin
                MEM      <= idex_mem;
                exmem_wb <= idex_wb;
                if (stall) begin
                    EX       <= '0;
                    idex_mem <= '0;
                    idex_wb  <= '0;
                end else begin
                    EX       <= dec_ex;
                    idex_mem <= dec_mem;
                    idex_wb  <= dec_wb;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mul_busy   <= 1'b0;
            mul_start  <= 1'b0;
            hilo_write <= 1'b0;
        end else begin
            mul_start  <= 1'b0;
            hilo_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mul_go) begin
                        state     <= ST_BUSY;
                        cnt       <= CNT_W'(MUL_LATENCY);
                        mul_start <= 1'b1;
                        mul_busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        mul_busy   <= 1'b0;
                        hilo_write <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    mul_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: decode table vectors plus hand-built
// load-use, branch-flush, multiply-interlock and reset-mid-multiply sequences.
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       branch_taken;
    logic [3:0] EX;
    logic [2:0] MEM;
    logic [1:0] WB;
    logic       Jump;
    logic       JumpReg;
    logic       pc_write;
    logic       ifid_write;
    logic       flush_ifid;
    logic       mul_start;
    logic       mul_busy;
    logic       hilo_write;
    logic       illegal_op;

    int n_vec = 0;
    int n_err = 0;

    pipe_control_unit #(.MUL_LATENCY(4), .CNT_W(8), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .EX(EX), .MEM(MEM), .WB(WB), .Jump(Jump), .JumpReg(JumpReg),
        .pc_write(pc_write), .ifid_write(ifid_write), .flush_ifid(flush_ifid),
        .mul_start(mul_start), .mul_busy(mul_busy), .hilo_write(hilo_write),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic [3:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
        logic       jump;
        logic       jr;
        logic       ill;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{6'd35, 6'd0,  4'b0001, 3'b100, 2'b11, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{6'd43, 6'd0,  4'b0001, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{6'd4,  6'd0,  4'b0010, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{6'd12, 6'd0,  4'b0111, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{6'd0,  6'd32, 4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{6'd0,  6'd16, 4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{6'd2,  6'd0,  4'b0000, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{6'd0,  6'd8,  4'b0000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{6'd63, 6'd0,  4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{6'd0,  6'd18, 4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{6'd5,  6'd0,  4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{6'd0,  6'd0,  4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; OpCode = 6'd0; Funct = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
        ex_rt = 5'd0; branch_taken = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ex", 32'(EX), 32'd0);
        chk("rst_mem", 32'(MEM), 32'd0);
        chk("rst_wb", 32'(WB), 32'd0);
        chk("rst_busy", 32'(mul_busy), 32'd0);
        chk("rst_start", 32'(mul_start), 32'd0);
        chk("rst_hilo", 32'(hilo_write), 32'd0);
        chk("rst_pcw", 32'(pc_write), 32'd1);
        chk("rst_ifidw", 32'(ifid_write), 32'd1);
        chk("rst_flush", 32'(flush_ifid), 32'd0);

        // decode table: EX one edge later, MEM two, WB three
        for (int i = 0; i < 12; i++) begin
            OpCode = tbl[i].op; Funct = tbl[i].funct;
            id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd0;
            #1;
            chk("tbl_jump", 32'(Jump), 32'(tbl[i].jump));
            chk("tbl_jr", 32'(JumpReg), 32'(tbl[i].jr));
            chk("tbl_illegal", 32'(illegal_op), 32'(tbl[i].ill));
            chk("tbl_pcw", 32'(pc_write), 32'd1);
            chk("tbl_flush", 32'(flush_ifid), 32'(tbl[i].jump));
            chk("tbl_no_x", 32'($isunknown({EX, MEM, WB, Jump, JumpReg, pc_write, ifid_write,
                flush_ifid, mul_start, mul_busy, hilo_write, illegal_op})), 32'd0);
            tick();
            chk("tbl_ex", 32'(EX), 32'(tbl[i].ex));
            if (i >= 1) chk("tbl_mem", 32'(MEM), 32'(tbl[i-1].mem));
            if (i >= 2) chk("tbl_wb", 32'(WB), 32'(tbl[i-2].wb));
        end

        // load-use with rt=5
        OpCode = 6'd35; Funct = 6'd0; id_rs = 5'd0; id_rt = 5'd5; ex_rt = 5'd0;
        #1;
        chk("lu_lw_pcw", 32'(pc_write), 32'd1);
        tick();
        OpCode = 6'd0; Funct = 6'd32; id_rs = 5'd5; id_rt = 5'd6; ex_rt = 5'd5;
        #1;
        chk("lu_stall_pcw", 32'(pc_write), 32'd0);
        chk("lu_stall_ifidw", 32'(ifid_write), 32'd0);
        chk("lu_stall_flush", 32'(flush_ifid), 32'd0);
        tick();
        chk("lu_bubble_ex", 32'(EX), 32'd0);
        chk("lu_resume_pcw", 32'(pc_write), 32'd1);
        tick();
        chk("lu_add_ex", 32'(EX), 32'hC);

        // same pattern through $0 must not stall
        OpCode = 6'd35; Funct = 6'd0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        tick();
        OpCode = 6'd0; Funct = 6'd32; id_rs = 5'd0; id_rt = 5'd6; ex_rt = 5'd0;
        #1;
        chk("lu_r0_pcw", 32'(pc_write), 32'd1);
        tick();
        chk("lu_r0_ex", 32'(EX), 32'hC);

        // taken branch overrides a simultaneous load-use stall
        OpCode = 6'd35; Funct = 6'd0; id_rs = 5'd0; id_rt = 5'd5; ex_rt = 5'd0;
        tick();
        OpCode = 6'd0; Funct = 6'd32; id_rs = 5'd5; id_rt = 5'd6; ex_rt = 5'd5;
        branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(flush_ifid), 32'd1);
        chk("br_pcw", 32'(pc_write), 32'd1);
        chk("br_ifidw", 32'(ifid_write), 32'd1);
        tick();
        branch_taken = 1'b0;
        chk("br_ex", 32'(EX), 32'd0);
        chk("br_mem", 32'(MEM), 32'd0);

        // MULTU then dependent MFLO, latency 4
        OpCode = 6'd0; Funct = 6'd25; id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd0;
        #1;
        chk("mul_issue_pcw", 32'(pc_write), 32'd1);
        tick();
        Funct = 6'd18;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("mul_busy", 32'(mul_busy), 32'd1);
            chk("mul_stall_pcw", 32'(pc_write), 32'd0);
            chk("mul_hilo_early", 32'(hilo_write), 32'd0);
            chk("mul_start", 32'(mul_start), (k == 1) ? 32'd1 : 32'd0);
            chk("mul_ex", 32'(EX), (k == 1) ? 32'hC : 32'd0);
            tick();
        end
        #1;
        chk("mul_done_busy", 32'(mul_busy), 32'd0);
        chk("mul_hilo", 32'(hilo_write), 32'd1);
        chk("mul_release_pcw", 32'(pc_write), 32'd1);
        tick();
        chk("mul_hilo_pulse", 32'(hilo_write), 32'd0);
        chk("mul_mflo_ex", 32'(EX), 32'hC);

        // reset two cycles into a multiply: no hilo_write afterwards
        Funct = 6'd25;
        #1;
        tick();
        Funct = 6'd0;
        #1;
        chk("mrst_busy_pre", 32'(mul_busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 32'(mul_busy), 32'd0);
        chk("mrst_hilo", 32'(hilo_write), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mrst_hilo_after", 32'(hilo_write), 32'd0);
            chk("mrst_busy_after", 32'(mul_busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
